// File: rtl/multicycle_control.sv
// Multicycle MIPS-subset sequencing controller: decodes opcode/funct and drives
// every datapath select, strobe and ALU control code, with memory-ready stalls.
module multicycle_control (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       pc_write_cond,
   output logic       i_or_d,
   output logic       mem_read,
   output logic       mem_write,
   output logic       ir_write,
   output logic       mem_to_reg,
   output logic       reg_dst,
   output logic       reg_write,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] pc_source,
   output logic [3:0] alu_ctrl,
   output logic [3:0] state,
   output logic       instr_done,
   output logic       illegal
);

   typedef enum logic [3:0] {
      s_fetch     = 4'd0,
      s_decode    = 4'd1,
      s_mem_addr  = 4'd2,
      s_mem_read  = 4'd3,
      s_mem_wb    = 4'd4,
      s_mem_write = 4'd5,
      s_execute   = 4'd6,
      s_r_wb      = 4'd7,
      s_branch    = 4'd8,
      s_jump      = 4'd9,
      s_addi_exec = 4'd10,
      s_addi_wb   = 4'd11,
      s_halt      = 4'd12
   } state_t;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       mem_to_reg;
      logic       reg_dst;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] pc_source;
      logic [3:0] alu_ctrl;
      logic       instr_done;
      logic       illegal;
   } ctl_t;

   localparam logic [5:0] op_rtype = 6'b000000;
   localparam logic [5:0] op_lw    = 6'b100011;
   localparam logic [5:0] op_sw    = 6'b101011;
   localparam logic [5:0] op_beq   = 6'b000100;
   localparam logic [5:0] op_j     = 6'b000010;
   localparam logic [5:0] op_addi  = 6'b001000;

   localparam logic [3:0] alu_and = 4'b0000;
   localparam logic [3:0] alu_or  = 4'b0001;
   localparam logic [3:0] alu_add = 4'b0010;
   localparam logic [3:0] alu_sub = 4'b0110;
   localparam logic [3:0] alu_slt = 4'b0111;
   localparam logic [3:0] alu_nor = 4'b1100;

   state_t     state_q;
   state_t     nxt;
   ctl_t       ctl_q;
   logic       is_load;
   logic       qual;
   logic       run;
   logic       unused_zero;

   assign unused_zero = zero;

   function automatic logic funct_ok(input logic [5:0] f);
      case (f)
         6'b100000, 6'b100010, 6'b100100,
         6'b100101, 6'b100111, 6'b101010: funct_ok = 1'b1;
         default:                         funct_ok = 1'b0;
      endcase
   endfunction

   function automatic logic [3:0] funct_alu(input logic [5:0] f);
      case (f)
         6'b100010: funct_alu = alu_sub;
         6'b100100: funct_alu = alu_and;
         6'b100101: funct_alu = alu_or;
         6'b100111: funct_alu = alu_nor;
         6'b101010: funct_alu = alu_slt;
         default:   funct_alu = alu_add;
      endcase
   endfunction

   // Moore output pattern of a state; fetch/mem_write strobes are qualified by mem_ready later.
   function automatic ctl_t decode(input state_t s, input logic [5:0] f);
      ctl_t c;
      c = '0;
      case (s)
         s_fetch: begin
            c.mem_read  = 1'b1;
            c.ir_write  = 1'b1;
            c.pc_write  = 1'b1;
            c.alu_src_b = 2'b01;
            c.alu_ctrl  = alu_add;
         end
         s_decode: begin
            c.alu_src_b = 2'b11;
            c.alu_ctrl  = alu_add;
         end
         s_mem_addr, s_addi_exec: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = 2'b10;
            c.alu_ctrl  = alu_add;
         end
         s_mem_read: begin
            c.i_or_d   = 1'b1;
            c.mem_read = 1'b1;
         end
         s_mem_wb: begin
            c.reg_write  = 1'b1;
            c.mem_to_reg = 1'b1;
            c.instr_done = 1'b1;
         end
         s_mem_write: begin
            c.i_or_d     = 1'b1;
            c.mem_write  = 1'b1;
            c.instr_done = 1'b1;
         end
         s_execute: begin
            c.alu_src_a = 1'b1;
            c.alu_ctrl  = funct_alu(f);
         end
         s_r_wb: begin
            c.reg_write  = 1'b1;
            c.reg_dst    = 1'b1;
            c.instr_done = 1'b1;
         end
         s_branch: begin
            c.alu_src_a     = 1'b1;
            c.alu_ctrl      = alu_sub;
            c.pc_write_cond = 1'b1;
            c.pc_source     = 2'b01;
            c.instr_done    = 1'b1;
         end
         s_jump: begin
            c.pc_write   = 1'b1;
            c.pc_source  = 2'b10;
            c.instr_done = 1'b1;
         end
         s_addi_wb: begin
            c.reg_write  = 1'b1;
            c.instr_done = 1'b1;
         end
         s_halt:  c.illegal = 1'b1;
         default: c = '0;
      endcase
      return c;
   endfunction

   always_comb begin
      nxt = state_q;
      case (state_q)
         s_fetch:     if (mem_ready) nxt = s_decode;
         s_decode: begin
            case (opcode)
               op_lw, op_sw: nxt = s_mem_addr;
               op_rtype:     nxt = funct_ok(funct) ? s_execute : s_halt;
               op_beq:       nxt = s_branch;
               op_j:         nxt = s_jump;
               op_addi:      nxt = s_addi_exec;
               default:      nxt = s_halt;
            endcase
         end
         s_mem_addr:  nxt = is_load ? s_mem_read : s_mem_write;
         s_mem_read:  if (mem_ready) nxt = s_mem_wb;
         s_mem_wb:    nxt = s_fetch;
         s_mem_write: if (mem_ready) nxt = s_fetch;
         s_execute:   nxt = s_r_wb;
         s_r_wb:      nxt = s_fetch;
         s_branch:    nxt = s_fetch;
         s_jump:      nxt = s_fetch;
         s_addi_exec: nxt = s_addi_wb;
         s_addi_wb:   nxt = s_fetch;
         s_halt:      nxt = s_halt;
         default:     nxt = s_fetch;
      endcase
   end

   // Outputs are registered from the next state; funct is only consumed on the
   // decode->execute transition and is held stable by the datapath thereafter.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= s_fetch;
         ctl_q   <= decode(s_fetch, funct);
         is_load <= 1'b0;
      end else begin
         state_q <= nxt;
         ctl_q   <= decode(nxt, funct);
         if (state_q == s_decode) is_load <= (opcode == op_lw);
      end
   end

   assign qual = ((state_q == s_fetch) || (state_q == s_mem_write)) ? mem_ready : 1'b1;
   assign run  = ~reset;

   assign pc_write      = run & ctl_q.pc_write & qual;
   assign ir_write      = run & ctl_q.ir_write & qual;
   assign instr_done    = run & ctl_q.instr_done & qual;
   assign pc_write_cond = run & ctl_q.pc_write_cond;
   assign i_or_d        = run & ctl_q.i_or_d;
   assign mem_read      = run & ctl_q.mem_read;
   assign mem_write     = run & ctl_q.mem_write;
   assign mem_to_reg    = run & ctl_q.mem_to_reg;
   assign reg_dst       = run & ctl_q.reg_dst;
   assign reg_write     = run & ctl_q.reg_write;
   assign alu_src_a     = run & ctl_q.alu_src_a;
   assign alu_src_b     = run ? ctl_q.alu_src_b : '0;
   assign pc_source     = run ? ctl_q.pc_source : '0;
   assign alu_ctrl      = run ? ctl_q.alu_ctrl : '0;
   assign illegal       = run & ctl_q.illegal;
   assign state         = run ? state_q : '0;

endmodule
